// File: rtl/generic_ccg_pkg.sv
// Shared types and constants for the multi-channel clock-gate controller.
// Used by the channel controller and the top level.
package generic_ccg_pkg;

   typedef enum logic [1:0] {
      CCG_ON   = 2'd0,
      CCG_HYST = 2'd1,
      CCG_OFF  = 2'd2
   } ccg_state_e;

   localparam int unsigned CCG_MAX_CNT_W = 64;

   // Saturation value of a w-bit counter, clamped to 64 bits.
   function automatic logic [CCG_MAX_CNT_W-1:0] ccg_sat_val(input int unsigned w);
      logic [CCG_MAX_CNT_W-1:0] v;
      if (w >= CCG_MAX_CNT_W) v = '1;
      else                    v = (64'd1 << w) - 64'd1;
      return v;
   endfunction

endpackage

// File: rtl/generic_ccg_ctrl_if.sv
// Control/status bundle between block enable logic and the clock-gate controller.
// master = requester side, slave = controller side.
interface generic_ccg_ctrl_if
   import generic_ccg_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned HYST_W = 4,
   parameter int unsigned CNT_W  = 16
);
   logic [NUM_CH-1:0]       en;
   logic                    force_en;
   logic                    te;
   logic [HYST_W-1:0]       hyst_cyc;
   logic [NUM_CH-1:0]       wake_req;
   logic [NUM_CH-1:0]       wake_ack;
   logic [NUM_CH-1:0]       out_clk;
   logic [NUM_CH-1:0]       ch_on;
   logic                    cnt_clr;
   logic [NUM_CH*CNT_W-1:0] gated_cnt;

   modport master (
      output en, force_en, te, hyst_cyc, wake_req, cnt_clr,
      input  wake_ack, out_clk, ch_on, gated_cnt
   );

   modport slave (
      input  en, force_en, te, hyst_cyc, wake_req, cnt_clr,
      output wake_ack, out_clk, ch_on, gated_cnt
   );
endinterface

// File: rtl/generic_ccg_ctrl_chan.sv
// One gated channel: ON/HYST/OFF FSM, hysteresis countdown, wake_ack and gated-cycle counter.
// ch_on and wake_ack are registered (1 cycle); requests are levels, no backpressure.
module ccg_chan_ctrl
   import generic_ccg_pkg::*;
#(
   parameter int unsigned HYST_W   = 4,
   parameter int unsigned CNT_W    = 16,
   parameter bit          RESET_ON = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic              i_force_en,
   input  logic              i_wake_req,
   input  logic [HYST_W-1:0] i_hyst_cyc,
   input  logic              i_cnt_clr,
   output logic              o_ch_on,
   output logic              o_wake_ack,
   output logic [CNT_W-1:0]  o_gated_cnt
);
   localparam ccg_state_e       RST_STATE = RESET_ON ? CCG_ON : CCG_OFF;
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(ccg_sat_val(CNT_W));

   ccg_state_e        r_state, w_state_nxt;
   logic [HYST_W-1:0] r_hcnt, w_hcnt_nxt;
   logic              r_ch_on;
   logic              r_wake_ack;
   logic [CNT_W-1:0]  r_gcnt;
   logic              w_req;

   assign w_req = i_en | i_force_en | i_wake_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RST_STATE;
         r_hcnt     <= '0;
         r_ch_on    <= RESET_ON;
         r_wake_ack <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hcnt     <= w_hcnt_nxt;
         r_ch_on    <= (w_state_nxt != CCG_OFF);
         r_wake_ack <= i_wake_req & r_ch_on;
      end
   end

   // A request always wins, including on the final hysteresis cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_hcnt_nxt  = r_hcnt;
      case (r_state)
         CCG_ON: begin
            if (!w_req) begin
               if (i_hyst_cyc == '0) begin
                  w_state_nxt = CCG_OFF;
               end else begin
                  w_state_nxt = CCG_HYST;
                  w_hcnt_nxt  = i_hyst_cyc;
               end
            end
         end
         CCG_HYST: begin
            if (w_req) begin
               w_state_nxt = CCG_ON;
               w_hcnt_nxt  = '0;
            end else if (r_hcnt <= HYST_W'(1)) begin
               w_state_nxt = CCG_OFF;
               w_hcnt_nxt  = '0;
            end else begin
               w_hcnt_nxt  = r_hcnt - HYST_W'(1);
            end
         end
         CCG_OFF: begin
            if (w_req) w_state_nxt = CCG_ON;
         end
         default: begin
            w_state_nxt = RST_STATE;
            w_hcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gcnt <= '0;
      end else if (i_cnt_clr) begin
         r_gcnt <= '0;
      end else if (!r_ch_on && (r_gcnt != CNT_SAT)) begin
         r_gcnt <= r_gcnt + CNT_W'(1);
      end
   end

   assign o_ch_on     = r_ch_on;
   assign o_wake_ack  = r_wake_ack;
   assign o_gated_cnt = r_gcnt;
endmodule

// File: rtl/generic_clkgate.sv
// Leaf clock gate: latch enable while clk is low, AND with clk; te overrides en.
// Zero-cycle; enable changes take effect at the next rising edge of clk.
module generic_clkgate (
   input  logic clk,
   input  logic en,
   input  logic te,
   output logic clk_out
);
   logic r_en_lat;

   always_latch begin
      if (!clk) r_en_lat = en | te;
   end

   assign clk_out = clk & r_en_lat;
endmodule

// File: rtl/generic_ccg_ctrl.sv
// Multi-channel clock-gate controller: one FSM + leaf gate per channel.
// ch_on/wake_ack registered (1 cycle); level requests, no backpressure.
module generic_ccg_ctrl
   import generic_ccg_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned HYST_W   = 4,
   parameter int unsigned CNT_W    = 16,
   parameter bit          RESET_ON = 1'b1
)(
   input logic              clk,
   input logic              rst,
   generic_ccg_ctrl_if.slave bus
);
   logic [NUM_CH-1:0]       w_ch_on;
   logic [NUM_CH-1:0]       w_wake_ack;
   logic [NUM_CH-1:0]       w_out_clk;
   logic [CNT_W-1:0]        w_gcnt [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] w_gcnt_flat;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ccg_chan_ctrl #(
         .HYST_W   (HYST_W),
         .CNT_W    (CNT_W),
         .RESET_ON (RESET_ON)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .i_en        (bus.en[g]),
         .i_force_en  (bus.force_en),
         .i_wake_req  (bus.wake_req[g]),
         .i_hyst_cyc  (bus.hyst_cyc),
         .i_cnt_clr   (bus.cnt_clr),
         .o_ch_on     (w_ch_on[g]),
         .o_wake_ack  (w_wake_ack[g]),
         .o_gated_cnt (w_gcnt[g])
      );

      generic_clkgate u_cg (
         .clk     (clk),
         .en      (w_ch_on[g]),
         .te      (bus.te),
         .clk_out (w_out_clk[g])
      );
   end

   always_comb begin
      w_gcnt_flat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_gcnt_flat[i*CNT_W +: CNT_W] = w_gcnt[i];
      end
   end

   assign bus.ch_on     = w_ch_on;
   assign bus.wake_ack  = w_wake_ack;
   assign bus.out_clk   = w_out_clk;
   assign bus.gated_cnt = w_gcnt_flat;
endmodule

// File: tb/tb_generic_ccg_ctrl.sv
// Directed bench for generic_ccg_ctrl (4 channels, 4-bit hysteresis, 4-bit counters).
module tb_generic_ccg_ctrl;
   import generic_ccg_pkg::*;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned HYST_W = 4;
   localparam int unsigned CNT_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   generic_ccg_ctrl_if #(.NUM_CH(NUM_CH), .HYST_W(HYST_W), .CNT_W(CNT_W)) bus ();

   generic_ccg_ctrl #(
      .NUM_CH(NUM_CH), .HYST_W(HYST_W), .CNT_W(CNT_W), .RESET_ON(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   int unsigned n_rise0 = 0;
   int unsigned n_rise1 = 0;
   int unsigned n_fall1 = 0;
   always @(posedge bus.out_clk[0]) n_rise0 <= n_rise0 + 1;
   always @(posedge bus.out_clk[1]) n_rise1 <= n_rise1 + 1;
   always @(negedge bus.ch_on[1])   n_fall1 <= n_fall1 + 1;

   task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h want 0x%h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int unsigned s0, s1, f1;

      bus.en = '0; bus.force_en = 1'b0; bus.te = 1'b0; bus.hyst_cyc = 4'd3;
      bus.wake_req = '0; bus.cnt_clr = 1'b0;

      // 1: reset to ON, then hysteresis of 3 before gating off
      #1 rst = 1'b1;
      #1;
      chk_eq("rst_ch_on",  16'(bus.ch_on), 16'h000F);
      chk_eq("rst_ack",    16'(bus.wake_ack), 16'h0000);
      chk_eq("rst_cnt",    bus.gated_cnt, 16'h0000);
      cyc(2);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk_eq("t1_hyst_on", 16'(bus.ch_on), 16'h000F);
      end
      cyc(1);
      chk_eq("t1_off", 16'(bus.ch_on), 16'h0000);
      chk_eq("t1_cnt0", bus.gated_cnt, 16'h0000);
      cyc(1);
      chk_eq("t1_cnt1", bus.gated_cnt, 16'h1111);

      // 5: saturation and clear priority
      cyc(20);
      chk_eq("t5_sat", bus.gated_cnt, 16'hFFFF);
      bus.cnt_clr = 1'b1;
      cyc(1);
      chk_eq("t5_clr", bus.gated_cnt, 16'h0000);
      bus.cnt_clr = 1'b0;
      cyc(1);
      chk_eq("t5_after_clr", bus.gated_cnt, 16'h1111);

      // 2: one-cycle en pulse on ch0 with hyst 3
      s0 = n_rise0; s1 = n_rise1;
      bus.en = 4'b0001;
      cyc(1);
      chk_eq("t2_on", 16'(bus.ch_on), 16'h0001);
      bus.en = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk_eq("t2_hyst", 16'(bus.ch_on), 16'h0001);
      end
      cyc(1);
      chk_eq("t2_off", 16'(bus.ch_on), 16'h0000);
      cyc(3);
      chk_eq("t2_rise0", 16'(n_rise0 - s0), 16'd4);
      chk_eq("t2_rise1", 16'(n_rise1 - s1), 16'd0);

      // 3: zero hysteresis, then re-request during hysteresis
      bus.hyst_cyc = 4'd0;
      bus.en = 4'b0010;
      cyc(1);
      chk_eq("t3_on", 16'(bus.ch_on), 16'h0002);
      bus.en = 4'b0000;
      cyc(1);
      chk_eq("t3_h0_off", 16'(bus.ch_on), 16'h0000);
      bus.hyst_cyc = 4'd5;
      bus.en = 4'b0010;
      cyc(1);
      chk_eq("t3_on2", 16'(bus.ch_on), 16'h0002);
      f1 = n_fall1;
      bus.en = 4'b0000;
      cyc(3);
      bus.en = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk_eq("t3_hold", 16'(bus.ch_on), 16'h0002);
      end
      chk_eq("t3_noglitch", 16'(n_fall1 - f1), 16'd0);
      // hyst_cyc change mid-countdown must not shorten it
      bus.en = 4'b0000;
      cyc(1);
      bus.hyst_cyc = 4'd1;
      cyc(4);
      chk_eq("t3_hyst_latched", 16'(bus.ch_on), 16'h0002);
      cyc(1);
      chk_eq("t3_off", 16'(bus.ch_on), 16'h0000);

      // 4: wake handshake on ch2 from OFF
      bus.hyst_cyc = 4'd2;
      bus.wake_req = 4'b0100;
      cyc(1);
      chk_eq("t4_on",   16'(bus.ch_on), 16'h0004);
      chk_eq("t4_ack0", 16'(bus.wake_ack), 16'h0000);
      cyc(1);
      chk_eq("t4_ack1", 16'(bus.wake_ack), 16'h0004);
      bus.wake_req = 4'b0000;
      cyc(1);
      chk_eq("t4_ack_drop", 16'(bus.wake_ack), 16'h0000);
      chk_eq("t4_hyst1", 16'(bus.ch_on), 16'h0004);
      cyc(1);
      chk_eq("t4_hyst2", 16'(bus.ch_on), 16'h0004);
      cyc(1);
      chk_eq("t4_off", 16'(bus.ch_on), 16'h0000);

      // force_en overrides everything, release follows ON rule
      bus.hyst_cyc = 4'd0;
      bus.force_en = 1'b1;
      cyc(1);
      chk_eq("force_on", 16'(bus.ch_on), 16'h000F);
      bus.force_en = 1'b0;
      cyc(1);
      chk_eq("force_rel", 16'(bus.ch_on), 16'h0000);

      // 6: async reset mid-HYST with an active ack
      bus.hyst_cyc = 4'd3;
      bus.en = 4'b0001;
      bus.wake_req = 4'b1000;
      cyc(1);
      bus.en = 4'b0000;
      cyc(2);
      chk_eq("t6_pre_on",  16'(bus.ch_on), 16'h0009);
      chk_eq("t6_pre_ack", 16'(bus.wake_ack), 16'h0008);
      #2 rst = 1'b1;
      #1;
      chk_eq("t6_rst_on",  16'(bus.ch_on), 16'h000F);
      chk_eq("t6_rst_ack", 16'(bus.wake_ack), 16'h0000);
      chk_eq("t6_rst_cnt", bus.gated_cnt, 16'h0000);
      bus.wake_req = 4'b0000;
      bus.hyst_cyc = 4'd0;
      cyc(1);
      rst = 1'b0;
      cyc(1);
      chk_eq("t6_off", 16'(bus.ch_on), 16'h0000);

      // te runs the clock without touching ch_on or counters
      bus.te = 1'b1;
      s1 = n_rise1;
      cyc(5);
      chk_eq("te_rise1", 16'(n_rise1 - s1), 16'd5);
      chk_eq("te_ch_on", 16'(bus.ch_on), 16'h0000);
      chk_eq("te_cnt",   bus.gated_cnt, 16'h5555);
      bus.te = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
